// File: rtl/bresenham_pkg.sv
// Shared types and constants for the Bresenham line rasteriser.
package bresenham_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed unit steps applied to x/y along each axis.
  localparam logic signed [1:0] STEP_INC = 2'sb01;
  localparam logic signed [1:0] STEP_DEC = 2'sb11;

  function automatic int err_width(input int coord_w);
    return coord_w + 2;
  endfunction

endpackage

// File: rtl/bresenham_step.sv
// One Bresenham iteration: from the current err/x/y produces the next pixel position and error term.
module bresenham_step
  import bresenham_pkg::*;
#(
  parameter int COORD_W = 8,
  parameter int ERR_W   = err_width(COORD_W)
) (
  input  logic signed [ERR_W-1:0] err,
  input  logic signed [ERR_W-1:0] dx,
  input  logic signed [ERR_W-1:0] dy,
  input  logic signed [1:0]       sx,
  input  logic signed [1:0]       sy,
  input  logic [COORD_W-1:0]      x,
  input  logic [COORD_W-1:0]      y,
  output logic signed [ERR_W-1:0] err_next,
  output logic [COORD_W-1:0]      x_next,
  output logic [COORD_W-1:0]      y_next
);

  // e2 gets one extra bit so doubling err can never wrap before the compares.
  logic signed [ERR_W:0] e2;
  logic signed [ERR_W:0] dx_ext;
  logic signed [ERR_W:0] dy_ext;
  logic                  step_x;
  logic                  step_y;
  logic [COORD_W-1:0]    sx_ext;
  logic [COORD_W-1:0]    sy_ext;

  assign e2     = {err, 1'b0};
  assign dx_ext = {dx[ERR_W-1], dx};
  assign dy_ext = {dy[ERR_W-1], dy};

  assign step_x = (e2 >= dy_ext);
  assign step_y = (e2 <= dx_ext);

  assign sx_ext = {{(COORD_W-2){sx[1]}}, sx};
  assign sy_ext = {{(COORD_W-2){sy[1]}}, sy};

  assign err_next = err + (step_x ? dy : {ERR_W{1'b0}}) + (step_y ? dx : {ERR_W{1'b0}});
  assign x_next   = step_x ? x + sx_ext : x;
  assign y_next   = step_y ? y + sy_ext : y;

endmodule

// File: rtl/bresenham_stream.sv
// Bresenham line rasteriser streaming one pixel per accepted valid/ready handshake.
module bresenham_stream
  import bresenham_pkg::*;
#(
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_last
);

  localparam int ERR_W = err_width(COORD_W);

  state_t                   state_reg, state_next;
  logic [COORD_W-1:0]       x_reg, x_next, y_reg, y_next;
  logic [COORD_W-1:0]       x1_reg, x1_next, y1_reg, y1_next;
  logic signed [ERR_W-1:0]  err_reg, err_next;
  logic signed [ERR_W-1:0]  dx_reg, dx_next, dy_reg, dy_next;
  logic signed [1:0]        sx_reg, sx_next, sy_reg, sy_next;
  logic                     last_reg, last_next;

  logic [COORD_W-1:0]       mag_x, mag_y;
  logic signed [ERR_W-1:0]  start_dx, start_dy;
  logic signed [ERR_W-1:0]  nxt_err;
  logic [COORD_W-1:0]       nxt_x, nxt_y;

  assign mag_x    = (x1 >= x0) ? x1 - x0 : x0 - x1;
  assign mag_y    = (y1 >= y0) ? y1 - y0 : y0 - y1;
  assign start_dx = ERR_W'(mag_x);
  assign start_dy = -$signed(ERR_W'(mag_y));

  bresenham_step #(
    .COORD_W (COORD_W),
    .ERR_W   (ERR_W)
  ) u_step (
    .err      (err_reg),
    .dx       (dx_reg),
    .dy       (dy_reg),
    .sx       (sx_reg),
    .sy       (sy_reg),
    .x        (x_reg),
    .y        (y_reg),
    .err_next (nxt_err),
    .x_next   (nxt_x),
    .y_next   (nxt_y)
  );

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    x1_next    = x1_reg;
    y1_next    = y1_reg;
    err_next   = err_reg;
    dx_next    = dx_reg;
    dy_next    = dy_reg;
    sx_next    = sx_reg;
    sy_next    = sy_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          x_next     = x0;
          y_next     = y0;
          x1_next    = x1;
          y1_next    = y1;
          dx_next    = start_dx;
          dy_next    = start_dy;
          sx_next    = (x0 < x1) ? STEP_INC : STEP_DEC;
          sy_next    = (y0 < y1) ? STEP_INC : STEP_DEC;
          err_next   = start_dx + start_dy;
          last_next  = (x0 == x1) && (y0 == y1);
          state_next = DRAW;
        end
      end
      DRAW: begin
        // Abort wins over a simultaneous final handshake: no done pulse.
        if (abort) begin
          state_next = IDLE;
          last_next  = 1'b0;
        end else if (pix_ready) begin
          if (last_reg) begin
            state_next = DONE;
            last_next  = 1'b0;
          end else begin
            x_next    = nxt_x;
            y_next    = nxt_y;
            err_next  = nxt_err;
            last_next = (nxt_x == x1_reg) && (nxt_y == y1_reg);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      x1_reg    <= '0;
      y1_reg    <= '0;
      err_reg   <= '0;
      dx_reg    <= '0;
      dy_reg    <= '0;
      sx_reg    <= STEP_INC;
      sy_reg    <= STEP_INC;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      x1_reg    <= x1_next;
      y1_reg    <= y1_next;
      err_reg   <= err_next;
      dx_reg    <= dx_next;
      dy_reg    <= dy_next;
      sx_reg    <= sx_next;
      sy_reg    <= sy_next;
      last_reg  <= last_next;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign pix_valid = (state_reg == DRAW);
  assign px        = x_reg;
  assign py        = y_reg;
  assign pix_last  = last_reg;

endmodule
